// File: rtl/mult_dispatch.sv
// mult_dispatch: issue-side initiator for the mult functional unit.
// Forwards MUL/DIV/REM class ops to the mult unit with a valid/ready handshake,
// collects its unstalled results into a credit-protected FIFO, and drains
// in-flight multiplier results after a flush.
// Optional feature macro: MULT_DISPATCH_BYPASS_EN (same-cycle result-to-writeback
// bypass when the FIFO is empty).
// fu_data layout (MSB..LSB): {operator[7:0], operand_a[XLEN-1:0], operand_b[XLEN-1:0], trans_id}
module mult_dispatch #(
  parameter int unsigned CVA6Cfg       = 32'd0,
  parameter int unsigned DEPTH         = 32'd4,
  parameter int unsigned MUL_LATENCY   = 32'd2,
  parameter int unsigned XLEN          = 32'd32,
  parameter int unsigned TRANS_ID_BITS = 32'd3,
  parameter int unsigned FU_DATA_W     = 32'd8 + 32'd2 * XLEN + TRANS_ID_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [FU_DATA_W-1:0]     issue_data_i,
  output logic [FU_DATA_W-1:0]     fu_data_o,
  output logic                     mult_valid_o,
  input  logic                     mult_ready_i,
  output logic                     mult_flush_o,
  input  logic                     result_valid_i,
  input  logic [XLEN-1:0]          result_i,
  input  logic [TRANS_ID_BITS-1:0] result_trans_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o
);

  localparam int unsigned OP_W  = 32'd8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 32'd1;
  localparam int unsigned DRN_W = $clog2(MUL_LATENCY + 32'd1);
  localparam int unsigned ENT_W = XLEN + TRANS_ID_BITS;

  // Operator encodings of the ops this unit understands
  localparam logic [7:0] OP_MUL    = 8'h01;
  localparam logic [7:0] OP_MULH   = 8'h02;
  localparam logic [7:0] OP_MULHU  = 8'h03;
  localparam logic [7:0] OP_MULHSU = 8'h04;
  localparam logic [7:0] OP_MULW   = 8'h05;
  localparam logic [7:0] OP_CLMUL  = 8'h06;
  localparam logic [7:0] OP_CLMULH = 8'h07;
  localparam logic [7:0] OP_CLMULR = 8'h08;
  localparam logic [7:0] OP_SMUL8  = 8'h09;
  localparam logic [7:0] OP_UMUL8  = 8'h0A;
  localparam logic [7:0] OP_DIV    = 8'h10;
  localparam logic [7:0] OP_DIVU   = 8'h11;
  localparam logic [7:0] OP_DIVW   = 8'h12;
  localparam logic [7:0] OP_DIVUW  = 8'h13;
  localparam logic [7:0] OP_REM    = 8'h14;
  localparam logic [7:0] OP_REMU   = 8'h15;
  localparam logic [7:0] OP_REMW   = 8'h16;
  localparam logic [7:0] OP_REMUW  = 8'h17;

  typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_e;

  // Core configuration is carried through for integration only
  if (CVA6Cfg != 32'd0) begin : g_cfg_passthrough
  end

  state_e                   state_r, state_next;
  logic [DRN_W-1:0]         drain_cnt_r, drain_cnt_next;
  logic [CNT_W-1:0]         inflight_r, count_r;
  logic [CNT_W:0]           used;
  logic [PTR_W-1:0]         wr_ptr_r, rd_ptr_r;
  logic [ENT_W-1:0]         mem_r [DEPTH];
  logic                     div_busy_r;
  logic [TRANS_ID_BITS-1:0] div_id_r;

  logic [OP_W-1:0]          op;
  logic [TRANS_ID_BITS-1:0] issue_id;
  logic                     is_mul, is_div, is_run, has_credit;
  logic                     fwd, accept, bypass, push, pop, fifo_empty;

  assign op       = issue_data_i[FU_DATA_W-1 -: OP_W];
  assign issue_id = issue_data_i[TRANS_ID_BITS-1:0];

  // Decode the operator into mul / div class; anything else is neither
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULW,
      OP_CLMUL, OP_CLMULH, OP_CLMULR, OP_SMUL8, OP_UMUL8: is_mul = 1'b1;
      OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
      OP_REM, OP_REMU, OP_REMW, OP_REMUW:                 is_div = 1'b1;
      default: begin
        is_mul = 1'b0;
        is_div = 1'b0;
      end
    endcase
  end

  // Credit: every forwarded op must have a FIFO slot waiting for its result
  assign used       = {1'b0, inflight_r} + {1'b0, count_r};
  assign has_credit = (used < (CNT_W + 32'd1)'(DEPTH));
  assign is_run     = (state_r == RUN);
  assign fifo_empty = (count_r == {CNT_W{1'b0}});

  assign issue_ready_o = is_run & ~flush_i & has_credit &
                         (is_mul | (mult_ready_i & ~div_busy_r));
  assign fwd           = issue_valid_i & issue_ready_o & (is_mul | is_div);
  assign mult_valid_o  = fwd;
  assign fu_data_o     = issue_data_i;
  assign mult_flush_o  = flush_i;

  // Results are only taken in RUN for ops we know are outstanding
  assign accept = result_valid_i & is_run & ~flush_i & (inflight_r != {CNT_W{1'b0}});

`ifdef MULT_DISPATCH_BYPASS_EN
  assign bypass = accept & fifo_empty & wb_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign push       = accept & ~bypass;
  assign pop        = ~fifo_empty & wb_ready_i;
  assign wb_valid_o = ~fifo_empty | bypass;

  // Writeback data: FIFO head, or the live result when bypassing
  always_comb begin
    wb_result_o   = mem_r[rd_ptr_r][XLEN-1:0];
    wb_trans_id_o = mem_r[rd_ptr_r][ENT_W-1:XLEN];
    if (bypass) begin
      wb_result_o   = result_i;
      wb_trans_id_o = result_trans_id_i;
    end else begin
      wb_result_o   = mem_r[rd_ptr_r][XLEN-1:0];
      wb_trans_id_o = mem_r[rd_ptr_r][ENT_W-1:XLEN];
    end
  end

  // Next state: flush always (re)enters DRAIN for the full multiplier latency
  always_comb begin
    state_next     = state_r;
    drain_cnt_next = drain_cnt_r;
    if (flush_i) begin
      state_next     = DRAIN;
      drain_cnt_next = DRN_W'(MUL_LATENCY);
    end else begin
      case (state_r)
        RUN: begin
          state_next     = RUN;
          drain_cnt_next = {DRN_W{1'b0}};
        end
        DRAIN: begin
          if (drain_cnt_r <= DRN_W'(1'b1)) begin
            state_next     = RUN;
            drain_cnt_next = {DRN_W{1'b0}};
          end else begin
            state_next     = DRAIN;
            drain_cnt_next = drain_cnt_r - DRN_W'(1'b1);
          end
        end
        default: begin
          state_next     = RUN;
          drain_cnt_next = {DRN_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= RUN;
      drain_cnt_r <= {DRN_W{1'b0}};
    end else begin
      state_r     <= state_next;
      drain_cnt_r <= drain_cnt_next;
    end
  end

  // In-flight counter: +1 per forwarded op, -1 per accepted result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_r <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      inflight_r <= {CNT_W{1'b0}};
    end else begin
      case ({fwd, accept})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1'b1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1'b1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Single outstanding divide tracking; the divider is not pipelined
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_busy_r <= 1'b0;
      div_id_r   <= {TRANS_ID_BITS{1'b0}};
    end else if (flush_i) begin
      div_busy_r <= 1'b0;
    end else if (fwd && is_div) begin
      div_busy_r <= 1'b1;
      div_id_r   <= issue_id;
    end else if (result_valid_i && (result_trans_id_i == div_id_r)) begin
      div_busy_r <= 1'b0;
    end else begin
      div_busy_r <= div_busy_r;
    end
  end

  // Result FIFO: storage, pointers and occupancy; flush discards contents
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= {result_trans_id_i, result_i};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit accounting must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_r == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed self-checking bench for mult_dispatch (DEPTH=4, MUL_LATENCY=2).
module tb_mult_dispatch;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TID  = 3;
  localparam int unsigned FW   = 8 + 2 * XLEN + TID;

  localparam logic [7:0] T_MUL   = 8'h01;
  localparam logic [7:0] T_DIV   = 8'h10;
  localparam logic [7:0] T_OTHER = 8'h00;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [FW-1:0]   issue_data_i;
  logic [FW-1:0]   fu_data_o;
  logic            mult_valid_o;
  logic            mult_ready_i;
  logic            mult_flush_o;
  logic            result_valid_i;
  logic [XLEN-1:0] result_i;
  logic [TID-1:0]  result_trans_id_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [XLEN-1:0] wb_result_o;
  logic [TID-1:0]  wb_trans_id_o;

  int errors = 0;
  int checks = 0;

  mult_dispatch #(.DEPTH(4), .MUL_LATENCY(2), .XLEN(XLEN), .TRANS_ID_BITS(TID)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_data_i(issue_data_i), .fu_data_o(fu_data_o),
    .mult_valid_o(mult_valid_o), .mult_ready_i(mult_ready_i), .mult_flush_o(mult_flush_o),
    .result_valid_i(result_valid_i), .result_i(result_i), .result_trans_id_i(result_trans_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [FW-1:0] fu(input logic [7:0] op, input logic [TID-1:0] id);
    return {op, 32'h1234_5678, 32'h9ABC_DEF0, id};
  endfunction

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic result(input logic v, input logic [XLEN-1:0] d, input logic [TID-1:0] id);
    result_valid_i    = v;
    result_i          = d;
    result_trans_id_i = id;
  endtask

  task automatic issue(input logic v, input logic [7:0] op, input logic [TID-1:0] id);
    issue_valid_i = v;
    issue_data_i  = fu(op, id);
  endtask

  task automatic check_wb(input string tag, input logic [XLEN-1:0] d, input logic [TID-1:0] id);
    check({tag, "_valid"}, FW'(wb_valid_o), FW'(1'b1));
    check({tag, "_data"},  FW'(wb_result_o), FW'(d));
    check({tag, "_id"},    FW'(wb_trans_id_o), FW'(id));
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; mult_ready_i = 1'b0; wb_ready_i = 1'b0;
    issue(1'b0, T_OTHER, 3'd0);
    result(1'b0, 32'h0, 3'd0);
    #2;
    check("rst_wb_valid", FW'(wb_valid_o), FW'(1'b0));
    check("rst_mult_valid", FW'(mult_valid_o), FW'(1'b0));
    #10 rst_ni = 1'b1;
    tick();

    // 1: MUL id=3, result 0x2A id=3
    mult_ready_i = 1'b1;
    issue(1'b1, T_MUL, 3'd3);
    #1;
    check("t1_ready", FW'(issue_ready_o), FW'(1'b1));
    check("t1_mult_valid", FW'(mult_valid_o), FW'(1'b1));
    check("t1_fu_data", fu_data_o, fu(T_MUL, 3'd3));
    tick();
    issue(1'b0, T_MUL, 3'd0);
    wb_ready_i = 1'b1;
    result(1'b1, 32'h2A, 3'd3);
    #1;
`ifdef MULT_DISPATCH_BYPASS_EN
    check_wb("t1_bypass", 32'h2A, 3'd3);
`else
    check("t1_wb_not_yet", FW'(wb_valid_o), FW'(1'b0));
`endif
    tick();
    result(1'b0, 32'h0, 3'd0);
    #1;
`ifdef MULT_DISPATCH_BYPASS_EN
    check("t1_wb_after_bypass", FW'(wb_valid_o), FW'(1'b0));
`else
    check_wb("t1_wb", 32'h2A, 3'd3);
`endif
    tick();
    check("t1_wb_drained", FW'(wb_valid_o), FW'(1'b0));

    // 2: wb stalled, 5 back-to-back MULs: 4 accepted, 5th stalls until a pop
    wb_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, T_MUL, 3'(i));
      #1;
      check($sformatf("t2_ready_%0d", i), FW'(issue_ready_o), FW'(i < 4));
      tick();
    end
    check("t2_hold", FW'(issue_ready_o), FW'(1'b0));
    for (int i = 0; i < 4; i++) begin
      result(1'b1, 32'h100 + 32'(i), 3'(i));
      #1;
      check($sformatf("t2_ready_res_%0d", i), FW'(issue_ready_o), FW'(1'b0));
      tick();
    end
    result(1'b0, 32'h0, 3'd0);
    wb_ready_i = 1'b1;
    #1;
    check_wb("t2_pop0", 32'h100, 3'd0);
    check("t2_ready_pop_cycle", FW'(issue_ready_o), FW'(1'b0));
    tick();
    wb_ready_i = 1'b0;
    check("t2_ready_after_pop", FW'(issue_ready_o), FW'(1'b1));
    check("t2_mult_valid_after_pop", FW'(mult_valid_o), FW'(1'b1));
    tick();
    issue(1'b0, T_MUL, 3'd0);

    // 4: credit=1, result and issue together -> FIFO +1, inflight unchanged
    wb_ready_i = 1'b1;
    #1;
    check_wb("t4_pop1", 32'h101, 3'd1);
    tick();
    wb_ready_i = 1'b0;
    issue(1'b1, T_MUL, 3'd5);
    result(1'b1, 32'h104, 3'd4);
    #1;
    check("t4_ready_credit1", FW'(issue_ready_o), FW'(1'b1));
    tick();
    result(1'b0, 32'h0, 3'd0);
    issue(1'b1, T_MUL, 3'd6);
    #1;
    check("t4_ready_credit0", FW'(issue_ready_o), FW'(1'b0));
    issue(1'b0, T_MUL, 3'd0);
    wb_ready_i = 1'b1;
    #1;
    check_wb("t4_pop2", 32'h102, 3'd2);
    tick();
    check_wb("t4_pop3", 32'h103, 3'd3);
    tick();
    check_wb("t4_pop4", 32'h104, 3'd4);
    tick();
    wb_ready_i = 1'b0;
    check("t4_empty", FW'(wb_valid_o), FW'(1'b0));
    result(1'b1, 32'h105, 3'd5);
    tick();
    result(1'b0, 32'h0, 3'd0);
    check_wb("t4_res5", 32'h105, 3'd5);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    check("t4_empty2", FW'(wb_valid_o), FW'(1'b0));

    // 3: DIV id=1 then DIV id=2 -> id=2 held until id=1 returns and divider ready
    issue(1'b1, T_DIV, 3'd1);
    #1;
    check("t3_div1_ready", FW'(issue_ready_o), FW'(1'b1));
    check("t3_div1_valid", FW'(mult_valid_o), FW'(1'b1));
    tick();
    issue(1'b1, T_DIV, 3'd2);
    #1;
    check("t3_div2_busy", FW'(issue_ready_o), FW'(1'b0));
    check("t3_div2_novalid", FW'(mult_valid_o), FW'(1'b0));
    tick();
    mult_ready_i = 1'b0;
    result(1'b1, 32'h11, 3'd1);
    #1;
    check("t3_div2_res_cycle", FW'(issue_ready_o), FW'(1'b0));
    tick();
    result(1'b0, 32'h0, 3'd0);
    #1;
    check("t3_div2_not_ready", FW'(issue_ready_o), FW'(1'b0));
    mult_ready_i = 1'b1;
    #1;
    check("t3_div2_ready", FW'(issue_ready_o), FW'(1'b1));
    check("t3_div2_valid", FW'(mult_valid_o), FW'(1'b1));
    tick();
    issue(1'b0, T_MUL, 3'd0);
    result(1'b1, 32'h22, 3'd2);
    tick();
    result(1'b0, 32'h0, 3'd0);
    wb_ready_i = 1'b1;
    #1;
    check_wb("t3_wb1", 32'h11, 3'd1);
    tick();
    check_wb("t3_wb2", 32'h22, 3'd2);
    tick();
    check("t3_empty", FW'(wb_valid_o), FW'(1'b0));
    wb_ready_i = 1'b0;

    // Non-mult op: accepted but not forwarded
    issue(1'b1, T_OTHER, 3'd7);
    #1;
    check("other_ready", FW'(issue_ready_o), FW'(1'b1));
    check("other_not_fwd", FW'(mult_valid_o), FW'(1'b0));
    tick();

    // 5: two MULs in flight plus one buffered result, then flush
    issue(1'b1, T_MUL, 3'd1);
    tick();
    issue(1'b1, T_MUL, 3'd2);
    tick();
    issue(1'b1, T_MUL, 3'd3);
    result(1'b1, 32'h55, 3'd1);
    tick();
    result(1'b0, 32'h0, 3'd0);
    check("t5_fifo_nonempty", FW'(wb_valid_o), FW'(1'b1));
    flush_i = 1'b1;
    issue(1'b1, T_MUL, 3'd4);
    #1;
    check("t5_flush_ready", FW'(issue_ready_o), FW'(1'b0));
    check("t5_flush_mult_valid", FW'(mult_valid_o), FW'(1'b0));
    check("t5_mult_flush", FW'(mult_flush_o), FW'(1'b1));
    tick();
    flush_i = 1'b0;
    result(1'b1, 32'h66, 3'd2);
    #1;
    check("t5_drain1_wb", FW'(wb_valid_o), FW'(1'b0));
    check("t5_drain1_ready", FW'(issue_ready_o), FW'(1'b0));
    tick();
    result(1'b1, 32'h77, 3'd3);
    #1;
    check("t5_drain2_wb", FW'(wb_valid_o), FW'(1'b0));
    check("t5_drain2_ready", FW'(issue_ready_o), FW'(1'b0));
    tick();
    result(1'b0, 32'h0, 3'd0);
    #1;
    check("t5_run_ready", FW'(issue_ready_o), FW'(1'b1));
    check("t5_run_wb", FW'(wb_valid_o), FW'(1'b0));
    tick();
    issue(1'b0, T_MUL, 3'd0);
    result(1'b1, 32'h44, 3'd4);
    tick();
    result(1'b0, 32'h0, 3'd0);
    check_wb("t5_wb4", 32'h44, 3'd4);

    // 6: reset with 3 entries buffered
    issue(1'b1, T_MUL, 3'd5);
    tick();
    issue(1'b1, T_MUL, 3'd6);
    result(1'b1, 32'h45, 3'd5);
    tick();
    issue(1'b0, T_MUL, 3'd0);
    result(1'b1, 32'h46, 3'd6);
    tick();
    result(1'b0, 32'h0, 3'd0);
    check_wb("t6_head", 32'h44, 3'd4);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_wb_valid", FW'(wb_valid_o), FW'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, T_MUL, 3'(i));
      #1;
      check($sformatf("t6_credit_%0d", i), FW'(issue_ready_o), FW'(i < 4));
      tick();
    end
    issue(1'b0, T_MUL, 3'd0);
    check("t6_no_wb", FW'(wb_valid_o), FW'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
